frq_div: RTL and testbench
==========================

# frq_div

Clock-enable style frequency divider with a built-in BCD digit counter. Divides the board master clock `mclk` down to a slow, 50 % duty square wave `clk` and advances a 4-bit BCD count (0–9) once per `clk` period. Sits at the front of the BCD-counter/seven-segment display path and feeds the digit value to the segment decoder.

## Interface
- `DIV_HALF`, default 5: number of `mclk` cycles per `clk` half-period. Legal range 1 to 2^24. `clk` period is 2·`DIV_HALF` `mclk` cycles.
- `COUNT_MAX`, default 9: terminal value of `count` before wrap. Legal range 1–15.
- `mclk` input 1: master clock. All logic is on its rising edge. This is the single clock.
- `reset` input 1: asynchronous, active-low reset. Low clears all state immediately.
- `clk` output 1: divided clock, registered, 50 % duty.
- `count` output 4: BCD digit, registered, range 0..`COUNT_MAX`.

## Operation
- Internal prescaler `pcnt`:
  - Width is ceil(log2(`DIV_HALF`)), minimum 1.
  - Counts 0..`DIV_HALF`-1 on every `mclk` edge.
- Terminal edge (`pcnt` == `DIV_HALF`-1):
  - `pcnt` returns to 0.
  - `clk` toggles.
- Rising transition of `clk` (terminal edge while `clk` == 0):
  - `count` increments on the same `mclk` edge.
  - If `count` == `COUNT_MAX`, it wraps to 0 instead.
- Falling transition of `clk`: `count` holds.
- No other inputs. `clk` is a registered data output. Downstream logic in the `mclk` domain samples it as data or uses an equivalent enable. Do not run it through a generated clock tree inside this block.
- Reset asserted (`reset` = 0), including mid-period:
  - `pcnt` = 0, `clk` = 0, `count` = 0, effective at once, independent of `mclk`.
  - Everything holds while reset stays low.
- Reset deassertion is synchronised internally with a 2-flop release synchroniser. Counting resumes on the first `mclk` edge after the synchronised release.
- Glitch-free: `clk` and `count` change only on `mclk` rising edges, except for the async clear.

## Timing
- Let edge E1 be the first `mclk` rising edge on which internal reset is deasserted.
- The `clk` rise and the `count` update both land on edge E(`DIV_HALF`).
  - `count` becomes 1 there.
  - Latency is 0 cycles between the `clk` rise and the `count` update.
- First `clk` fall is at E(2·`DIV_HALF`).
- `count` sequence: 0,1,…,`COUNT_MAX`,0,…, one step per `clk` period.
- `count` wrap period is (`COUNT_MAX`+1)·2·`DIV_HALF` `mclk` cycles.
- `DIV_HALF` = 1: `clk` toggles every `mclk` cycle (period 2 cycles), and `count` advances every 2 cycles.
- Reset values: `clk` = 0, `count` = 4'd0.

## Structure
- Package `frq_div_pkg`:
  - `COUNT_W` = 4.
  - `DEF_DIV_HALF` = 5.
  - `DEF_COUNT_MAX` = 9.
  - Function `clog2_min1`, used for the prescaler width.
- One natural sub-module, `frq_div_prescaler`:
  - Contains the reset synchroniser, `pcnt` and `clk` toggle.
  - Outputs a one-cycle `rise_en` pulse on the terminal edge while `clk` == 0.
- The BCD counter stays in the top level, driven by `rise_en`.

## Test plan
All cases use `mclk` period 10 ns and the defaults unless stated.
1. Reset pulse: `reset` = 1, then 0 at 50 ns, then 1 at 60 ns -> `clk` = 0 and `count` = 0 during and immediately after reset. First `clk` rise 5 `mclk` edges after the synchronised release, with `count` = 1 on that edge.
2. Steady run for 1100 ns -> `clk` period 100 ns at 50 % duty. `count` steps 1…9, then 0 on the tenth rise, i.e. wrap at `count` == 9.
3. Reset asserted mid-high-phase (`count` = 6, `pcnt` = 3) -> `clk` and `count` read 0 before the next `mclk` edge, and the sequence restarts exactly as in case 1.
4. `DIV_HALF` = 1, `COUNT_MAX` = 3 -> `clk` toggles every edge. `count` sequence 1,2,3,0, changing every 20 ns.
5. `DIV_HALF` = 7 (odd) -> high phase and low phase each exactly 7 cycles. Checker reports `clk` edges only on `mclk` rising edges and no X on any output after the first post-reset edge.

Source files
------------

// File: rtl/frq_div_pkg.sv
// Shared constants and helpers for the frequency divider / BCD digit counter.
package frq_div_pkg;

    localparam int COUNT_W       = 4;
    localparam int DEF_DIV_HALF  = 5;
    localparam int DEF_COUNT_MAX = 9;

    // Bits needed to hold 0..value-1, never less than one bit so a
    // divide-by-one prescaler still has a legal (constant-zero) register.
    function automatic int clog2_min1(input int value);
        int w;
        w = $clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/frq_div_prescaler.sv
// Reset release synchroniser, half-period prescaler and divided-clock toggle.
// rise_en pulses for one mclk cycle on the edge where clk goes 0 -> 1.
module frq_div_prescaler
    import frq_div_pkg::*;
#(
    parameter int DIV_HALF = DEF_DIV_HALF
) (
    input  logic mclk,
    input  logic reset,
    output logic clk,
    output logic rise_en
);

    localparam int                PCNT_W    = clog2_min1(DIV_HALF);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(DIV_HALF - 1);
    localparam logic [PCNT_W-1:0] PCNT_ONE  = PCNT_W'(1);

    logic [1:0]        sync_q;
    logic              run;
    logic [PCNT_W-1:0] pcnt_q;
    logic [PCNT_W-1:0] pcnt_d;
    logic              clk_q;
    logic              clk_d;
    logic              terminal;

    // Two-flop release synchroniser: assertion is immediate, release is
    // retimed to mclk so every counter leaves reset on the same edge.
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign run = sync_q[1];

    // Next-state for the prescaler and the divided clock.
    always_comb begin
        terminal = (pcnt_q == PCNT_LAST);
        pcnt_d   = pcnt_q;
        clk_d    = clk_q;
        rise_en  = 1'b0;
        if (run) begin
            if (terminal) begin
                pcnt_d  = '0;
                clk_d   = ~clk_q;
                rise_en = ~clk_q;
            end else begin
                pcnt_d  = pcnt_q + PCNT_ONE;
            end
        end
    end

    // Prescaler and divided-clock registers, cleared asynchronously.
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            pcnt_q <= '0;
            clk_q  <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            clk_q  <= clk_d;
        end
    end

    assign clk = clk_q;

endmodule

// File: rtl/frq_div.sv
// Frequency divider with BCD digit counter. clk is a registered data output
// in the mclk domain; count advances on the same mclk edge that raises clk.
module frq_div
    import frq_div_pkg::*;
#(
    parameter int DIV_HALF  = DEF_DIV_HALF,
    parameter int COUNT_MAX = DEF_COUNT_MAX
) (
    input  logic               mclk,
    input  logic               reset,
    output logic               clk,
    output logic [COUNT_W-1:0] count
);

    localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(COUNT_MAX);
    localparam logic [COUNT_W-1:0] COUNT_ONE  = COUNT_W'(1);

    logic               rise_en;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;

    frq_div_prescaler #(
        .DIV_HALF (DIV_HALF)
    ) u_prescaler (
        .mclk    (mclk),
        .reset   (reset),
        .clk     (clk),
        .rise_en (rise_en)
    );

    // Digit advances once per divided-clock period, wrapping after COUNT_MAX.
    always_comb begin
        count_d = count_q;
        if (rise_en) begin
            if (count_q == COUNT_LAST) begin
                count_d = '0;
            end else begin
                count_d = count_q + COUNT_ONE;
            end
        end
    end

    // Digit register, cleared asynchronously with the rest of the block.
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_frq_div.sv
// Scoreboard bench for frq_div: three instances (defaults, DIV_HALF=1/COUNT_MAX=3,
// DIV_HALF=7) share mclk and reset. A driver pushes the expected outputs from
// an arithmetic model each cycle; a monitor pops and compares on the falling edge.
module tb_frq_div;

    localparam int NDUT = 3;
    localparam int D_A = 5, M_A = 9;
    localparam int D_B = 1, M_B = 3;
    localparam int D_C = 7, M_C = 9;

    typedef struct {
        int           cyc;
        logic [2:0]   clk;
        logic [3:0]   cnt [NDUT];
    } exp_t;

    logic       mclk;
    logic       reset_n;
    logic       clk_a, clk_b, clk_c;
    logic [3:0] cnt_a, cnt_b, cnt_c;

    int   total = 0;
    int   bad   = 0;
    int   rel   = 0;     // mclk edges seen with reset high since last release
    int   cyc   = 0;
    bit   edge_chk_en = 0;
    time  t_pos = 0;
    exp_t sb_q[$];

    frq_div #(.DIV_HALF(D_A), .COUNT_MAX(M_A)) dut_a (
        .mclk(mclk), .reset(reset_n), .clk(clk_a), .count(cnt_a));
    frq_div #(.DIV_HALF(D_B), .COUNT_MAX(M_B)) dut_b (
        .mclk(mclk), .reset(reset_n), .clk(clk_b), .count(cnt_b));
    frq_div #(.DIV_HALF(D_C), .COUNT_MAX(M_C)) dut_c (
        .mclk(mclk), .reset(reset_n), .clk(clk_c), .count(cnt_c));

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    always @(posedge mclk) t_pos = $time;

    // Reference: n counts mclk edges since E1 (n=0 means reset state).
    // clk is high during odd half-periods; rises occur at n = D, 3D, 5D, ...
    function automatic void ref_model(input int n, input int d, input int m,
                                      output logic c, output logic [3:0] k);
        int rises;
        c     = ((n / d) % 2) == 1;
        rises = (n + d) / (2 * d);
        k     = 4'(rises % (m + 1));
    endfunction

    // One mclk cycle: advance the model on the edge, then drive reset at +2
    // and push the outputs expected for the rest of this cycle.
    task automatic cycle(input bit rn);
        exp_t e;
        int   n;
        @(posedge mclk);
        if (reset_n) rel++;
        #2;
        if (!rn) rel = 0;
        reset_n = rn;
        cyc++;
        n = (!reset_n || rel <= 2) ? 0 : rel - 2;
        e.cyc = cyc;
        ref_model(n, D_A, M_A, e.clk[0], e.cnt[0]);
        ref_model(n, D_B, M_B, e.clk[1], e.cnt[1]);
        ref_model(n, D_C, M_C, e.clk[2], e.cnt[2]);
        sb_q.push_back(e);
        edge_chk_en = 1;
    endtask

    // Monitor: outputs are valid every cycle; compare away from the active edge.
    initial begin
        exp_t       e;
        logic       gc [NDUT];
        logic [3:0] gk [NDUT];
        forever begin
            @(negedge mclk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                gc[0] = clk_a; gc[1] = clk_b; gc[2] = clk_c;
                gk[0] = cnt_a; gk[1] = cnt_b; gk[2] = cnt_c;
                for (int i = 0; i < NDUT; i++) begin
                    total++;
                    if (gc[i] !== e.clk[i]) begin
                        bad++;
                        $display("FAIL clk dut%0d cyc=%0d got=%b want=%b", i, e.cyc, gc[i], e.clk[i]);
                    end
                    total++;
                    if (gk[i] !== e.cnt[i]) begin
                        bad++;
                        $display("FAIL count dut%0d cyc=%0d got=%0d want=%0d", i, e.cyc, gk[i], e.cnt[i]);
                    end
                end
            end
        end
    end

    // The divided clock may only move on an mclk rising edge outside reset.
    always @(clk_c) begin
        if (edge_chk_en && reset_n) begin
            total++;
            if (!(mclk === 1'b1 && $time == t_pos)) begin
                bad++;
                $display("FAIL clk_edge_align time=%0t mclk=%b last_pos=%0t", $time, mclk, t_pos);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time=%0t limit reached", $time);
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) cycle(1'b0);
        cycle(1'b1);
        repeat (130) cycle(1'b1);             // covers one full wrap of the default digit

        // Reset at a random point, then restart.
        repeat ($urandom_range(1, 40)) cycle(1'b1);
        cycle(1'b0);
        repeat (2) cycle(1'b0);
        cycle(1'b1);

        // Reset mid-high-phase of the default instance: count=6, pcnt=3 (n=58).
        while (rel < 59) cycle(1'b1);
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b1);
        repeat (150) cycle(1'b1);

        // Randomised run lengths and reset widths.
        repeat (6) begin
            repeat ($urandom_range(20, 300)) cycle(1'b1);
            repeat ($urandom_range(1, 3)) cycle(1'b0);
            cycle(1'b1);
        end
        repeat (60) cycle(1'b1);

        @(negedge mclk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
